// File: rtl/disp_pkg.sv
// Shared constants and anode decode for the display scan controller.
package disp_pkg;

    localparam int DIGITS = 4;
    localparam int NIB_W  = 4;
    localparam logic [DIGITS-1:0] AN_OFF = 4'b1111;

    // Active-low one-hot anode for the selected digit, or all off when dark.
    function automatic logic [DIGITS-1:0] an_decode(input logic [1:0] sel, input logic lit);
        return lit ? ~(4'b0001 << sel) : AN_OFF;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the terminal count as tick.
module tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    // Holding the count while disabled lets scanning resume mid-slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Display scan controller feeding a 4-bit 4:1 mux; new values commit only at frame wrap.
// Build option: LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DIGITS*NIB_W-1:0] load_data,
    output logic [NIB_W-1:0]        I0,
    output logic [NIB_W-1:0]        I1,
    output logic [NIB_W-1:0]        I2,
    output logic [NIB_W-1:0]        I3,
    output logic [1:0]              s,
    output logic [DIGITS-1:0]       an,
    output logic                    frame
);

    logic                    tick;
    logic                    wrap;
    logic                    xfer;
    logic                    pend_full;
    logic [DIGITS*NIB_W-1:0] pend_data;
    logic [NIB_W-1:0]        disp [DIGITS];
    logic                    blank;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    assign wrap       = tick && (s == 2'd3);
    assign xfer       = load_valid && load_ready;
    assign load_ready = !pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= 2'd0;
            frame     <= 1'b0;
            pend_full <= 1'b0;
            pend_data <= '0;
            for (int i = 0; i < DIGITS; i++) disp[i] <= '0;
        end else begin
            frame <= wrap;
            if (tick) s <= s + 2'd1;
            // A transfer needs an empty pending register, so it never collides with a commit.
            if (wrap && pend_full) begin
                for (int i = 0; i < DIGITS; i++) disp[i] <= pend_data[i*NIB_W +: NIB_W];
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend_data <= load_data;
                pend_full <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic hi_zero;

    always_comb begin
        hi_zero = 1'b1;
        blank   = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero = hi_zero && (disp[i] == '0);
            if (s == i[1:0]) blank = hi_zero;
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign an = an_decode(s, en && !blank);

    assign I0 = disp[0];
    assign I1 = disp[1];
    assign I2 = disp[2];
    assign I3 = disp[3];

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed display scan controller that sits directly upstream of the 4-bit 4:1 mux (`MUX441`). It accepts a 16-bit value over a valid/ready handshake and holds it as four nibbles that drive the mux data inputs `I0..I3`. It steps the mux select `s` on a prescaled tick and drives the matching active-low digit anodes. New values are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `DIV`, 50000: clock cycles per digit slot; legal range 1..2^24.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable; when low, scanning freezes and the display is blanked.
- `load_valid` in 1: upstream offers `load_data`.
- `load_ready` out 1: block can accept `load_data`.
- `load_data` in 16: `[3:0]` is digit 0, and so on up to `[15:12]` for digit 3.
- `I0`, `I1`, `I2`, `I3` out 4 each: displayed nibbles to the mux data inputs.
- `s` out 2: mux select, also the current digit index.
- `an` out 4: anodes, active-low; bit `i` lights digit `i`.
- `frame` out 1: one-cycle pulse when `s` wraps from 3 to 0.

## Operation
- **Reset state:** `I0..I3`=0, `s`=0, prescaler=0, pending register empty, `load_ready`=1, `frame`=0, `an`=4'b1110 (with `en`=1).
- **Prescaler:** counts 0..DIV-1 while `en`=1. `tick` is asserted when count==DIV-1; the count then returns to 0. With DIV=1, `tick` fires every enabled cycle.
- **Select:** on `tick`, `s` <= `s`+1 mod 4. When `s`==3 on a tick, `frame` pulses in the following cycle.
- **Anodes:** combinational decode of the registered `s`, `en` and display state, with `an` = ~(1<<`s`). When `en`=0, `an`=4'b1111.
- **Handshake:** a transfer occurs when `load_valid` && `load_ready`. The data goes into the pending register and `load_ready` drops the next cycle.
- **Commit at wrap:** on the tick where `s` wraps 3->0, a full pending register is copied into `I0..I3` and the pending register empties. `load_ready` returns to 1 the next cycle.
- **Accept coincides with wrap:** if a transfer happens on the same edge as the wrap, the data is captured as pending and commits at the following wrap.
- **Held data:** data in the pending register is never overwritten while `load_ready`=0. `load_data` is ignored when there is no transfer.
- **`en` low:** prescaler and `s` hold, and no commit occurs. The handshake still works: one value can be pending.
- **Reset mid-operation:** returns everything to the reset state immediately. Pending data is discarded.

## Timing
- **Digit slot:** DIV cycles; frame = 4*DIV cycles.
- **Select/anode alignment:** `s` and `an` change on the same edge; there is no skew.
- **Load-to-display latency:** 1 cycle to pending, then up to 4*DIV cycles to the next wrap. `I0..I3` update on the wrap edge.
- **Throughput:** at most one load per frame.

## Configuration
- **`LEADING_ZERO_BLANK_EN` defined:** digit `i` (i>=1) is blanked (`an`=4'b1111 during its slot) when the nibbles at index `i` and all higher indices are all zero. Digit 0 is always lit. The check uses the committed `I0..I3`.
- **Not defined:** every digit lights in its slot regardless of value.
- `s`, `frame` and handshake timing are identical in both builds.

## Structure
- **Shared package/header `disp_pkg`:** `DIGITS`=4, `NIB_W`=4, `AN_OFF`=4'b1111, and the anode decode function.
- **Sub-module `tick_gen`:** parameter `DIV`; ports `clk`, `rst_n`, `en` -> `tick`. The remainder (select counter, pending/display registers, anode decode) stays in `disp_scan_ctrl`.
- Outputs `I0..I3` and `s` connect directly to `MUX441` ports of the same names.

## Test plan
- **Reset:** DIV=4; assert `rst_n`=0 mid-frame. Require `s`=0, `an`=4'b1110, `I0..I3`=0 and `load_ready`=1 without waiting for a clock edge.
- **Scan:** DIV=4, `en`=1, hold 16 cycles. Require `s` sequence 0,1,2,3 with each value held 4 cycles, `an` 1110,1101,1011,0111, and a single `frame` pulse after the 3->0 wrap.
- **Load:** load 16'h1234 at cycle 2. Require `load_ready`=0 from cycle 3, and at the wrap `I0`=4, `I1`=3, `I2`=2, `I3`=1 with `load_ready`=1 one cycle later.
- **Backpressure:** while 16'h1234 is pending, offer 16'hA5A5 continuously. Require no transfer until `load_ready` returns, then 16'hA5A5 commits at the following wrap.
- **Blanking:** load 16'h0005. With `LEADING_ZERO_BLANK_EN`, require `an`=4'b1111 in slots 1-3 and 4'b1110 in slot 0. Without it, require the normal anode sequence.
- **Enable:** drop `en` while `s`=2 for 10 cycles. Require `s` held at 2, `an`=4'b1111 and no commit. Scanning resumes from the frozen prescaler count.
